// File: rtl/ch_expand.sv
// Channel-estimate expander: each accepted averaged I/Q estimate is replayed N times (N from parallel_mode).
// Latency: first copy on out_* one cycle after acceptance; copies issue back to back while out_rdy is high.
// Backpressure: copies hold while out_rdy is low; in_rdy rises only in IDLE or when the last copy is leaving.
module ch_expand #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [INPUT_WIDTH-1:0]  i_ch_avged,
  input  logic signed [INPUT_WIDTH-1:0]  q_ch_avged,
  input  logic                           in_vld,
  input  logic [1:0]                     parallel_mode,
  output logic                           in_rdy,
  output logic signed [OUTPUT_WIDTH-1:0] i_ch_exp,
  output logic signed [OUTPUT_WIDTH-1:0] q_ch_exp,
  output logic                           out_vld,
  output logic                           out_last,
  input  logic                           out_rdy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      cnt_q, cnt_d;   // index of the copy currently presented (1..N)
  logic [1:0]                      n_q, n_d;       // repetition count latched with the estimate
  logic signed [OUTPUT_WIDTH-1:0]  i_q, i_d;
  logic signed [OUTPUT_WIDTH-1:0]  q_q, q_d;
  logic                            vld_q, vld_d;
  logic                            last_q, last_d;
  logic                            accept;
  logic [1:0]                      n_new;

  // Mode 00 is treated the same as 11 (three copies).
  function automatic logic [1:0] decode_n(input logic [1:0] mode);
    case (mode)
      2'b01:   decode_n = 2'd1;
      2'b10:   decode_n = 2'd2;
      default: decode_n = 2'd3;
    endcase
  endfunction

  assign n_new  = decode_n(parallel_mode);
  assign accept = in_vld && in_rdy;

  // Ready is combinational so a new estimate can load on the same edge the last copy leaves.
  always_comb begin
    in_rdy = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    in_rdy = 1'b1;
        EMIT:    in_rdy = last_q && out_rdy;
        default: in_rdy = 1'b0;
      endcase
    end
  end

  // Next-state and output-register logic; everything holds unless a copy transfers or an estimate loads.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    i_d     = i_q;
    q_d     = q_q;
    vld_d   = vld_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EMIT;
          cnt_d   = 2'd1;
          n_d     = n_new;
          i_d     = OUTPUT_WIDTH'(i_ch_avged);
          q_d     = OUTPUT_WIDTH'(q_ch_avged);
          vld_d   = 1'b1;
          last_d  = (n_new == 2'd1);
        end
      end
      EMIT: begin
        if (out_rdy) begin
          if (last_q) begin
            if (accept) begin
              // Seamless reload: out_vld stays high across estimates.
              cnt_d  = 2'd1;
              n_d    = n_new;
              i_d    = OUTPUT_WIDTH'(i_ch_avged);
              q_d    = OUTPUT_WIDTH'(q_ch_avged);
              vld_d  = 1'b1;
              last_d = (n_new == 2'd1);
            end else begin
              // Data registers keep their last value while idle.
              state_d = IDLE;
              cnt_d   = 2'd0;
              vld_d   = 1'b0;
              last_d  = 1'b0;
            end
          end else begin
            cnt_d  = cnt_q + 2'd1;
            last_d = ((cnt_q + 2'd1) == n_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any held estimate and its outstanding copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      n_q     <= 2'd0;
      i_q     <= '0;
      q_q     <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      i_q     <= i_d;
      q_q     <= q_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign i_ch_exp = i_q;
  assign q_ch_exp = q_q;
  assign out_vld  = vld_q;
  assign out_last = last_q;

endmodule

// File: tb/tb_ch_expand.sv
// Testbench for ch_expand: directed scenarios plus randomized traffic against a copy-countdown model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Two instances: default 16/16 widths and a 12->16 instance for sign extension.
module tb_ch_expand;

  logic clk = 1'b0;
  logic rst;

  // 16/16 instance
  logic signed [15:0] i_in, q_in, i_out, q_out;
  logic               in_vld, in_rdy, out_vld, out_last, out_rdy;
  logic [1:0]         mode;

  // 12/16 instance
  logic signed [11:0] w_i_in, w_q_in;
  logic signed [15:0] w_i_out, w_q_out;
  logic               w_in_vld, w_in_rdy, w_out_vld, w_out_last, w_out_rdy;
  logic [1:0]         w_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ch_expand #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_ch_avged(i_in), .q_ch_avged(q_in), .in_vld(in_vld), .parallel_mode(mode),
    .in_rdy(in_rdy), .i_ch_exp(i_out), .q_ch_exp(q_out),
    .out_vld(out_vld), .out_last(out_last), .out_rdy(out_rdy)
  );

  ch_expand #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(16)) dut12 (
    .clk(clk), .rst(rst),
    .i_ch_avged(w_i_in), .q_ch_avged(w_q_in), .in_vld(w_in_vld), .parallel_mode(w_mode),
    .in_rdy(w_in_rdy), .i_ch_exp(w_i_out), .q_ch_exp(w_q_out),
    .out_vld(w_out_vld), .out_last(w_out_last), .out_rdy(w_out_rdy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; mode = 2'b00; i_in = '0; q_in = '0;
    w_in_vld = 1'b0; w_out_rdy = 1'b0; w_mode = 2'b00; w_i_in = '0; w_q_in = '0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy got %b exp 0", in_rdy); end
    step();
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    checks++; if (i_out !== 16'h0 || q_out !== 16'h0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", i_out, q_out); end
    checks++; if (w_out_vld !== 1'b0) begin errors++; $display("FAIL reset_w_out_vld got %b exp 0", w_out_vld); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_rdy got %b exp 1", in_rdy); end
    checks++; if (w_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_w_rdy got %b exp 1", w_in_rdy); end
    step();
  endtask

  task automatic test_basic();
    i_in = 16'sh1234; q_in = -16'sd5; mode = 2'b11; in_vld = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL basic_accept_rdy got %b exp 1", in_rdy); end
    step();
    in_vld = 1'b0; mode = 2'b01; i_in = 16'h7777; q_in = 16'h1111;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (out_vld !== (k <= 3)) begin errors++; $display("FAIL basic_vld k=%0d got %b exp %b", k, out_vld, k <= 3); end
      checks++; if (in_rdy !== (k >= 3)) begin errors++; $display("FAIL basic_rdy k=%0d got %b exp %b", k, in_rdy, k >= 3); end
      if (k <= 3) begin
        checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL basic_last k=%0d got %b exp %b", k, out_last, k == 3); end
        checks++; if (i_out !== 16'sh1234 || q_out !== -16'sd5) begin errors++; $display("FAIL basic_data k=%0d got %h/%h exp 1234/fffb", k, i_out, q_out); end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    i_in = 16'sh0AAA; q_in = 16'sh0555; mode = 2'b01; in_vld = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_a got %b exp 1", in_rdy); end
    step();
    i_in = 16'sh7FFF; q_in = -16'sh8000; mode = 2'b10;
    @(negedge clk);
    checks++; if (out_vld !== 1'b1 || out_last !== 1'b1 || i_out !== 16'sh0AAA || q_out !== 16'sh0555) begin
      errors++; $display("FAIL b2b_a vld=%b last=%b data=%h/%h exp 1 1 0aaa/0555", out_vld, out_last, i_out, q_out); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_b got %b exp 1", in_rdy); end
    step();
    in_vld = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++; if (out_vld !== 1'b1 || out_last !== (k == 2) || i_out !== 16'sh7FFF || q_out !== -16'sh8000) begin
        errors++; $display("FAIL b2b_b k=%0d vld=%b last=%b data=%h/%h exp 1 %b 7fff/8000", k, out_vld, out_last, i_out, q_out, k == 2); end
      step();
    end
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL b2b_end_vld got %b exp 0", out_vld); end
    step();
  endtask

  task automatic test_stall();
    i_in = 16'sh4321; q_in = -16'sh0124; mode = 2'b10; in_vld = 1'b1; out_rdy = 1'b0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL stall_accept_rdy got %b exp 1", in_rdy); end
    step();
    for (int k = 0; k < 4; k++) begin
      i_in = 16'($urandom); q_in = 16'($urandom); mode = 2'($urandom_range(0, 3));
      @(negedge clk);
      checks++; if (out_vld !== 1'b1 || out_last !== 1'b0 || in_rdy !== 1'b0) begin
        errors++; $display("FAIL stall_ctl k=%0d vld=%b last=%b rdy=%b exp 1 0 0", k, out_vld, out_last, in_rdy); end
      checks++; if (i_out !== 16'sh4321 || q_out !== -16'sh0124) begin
        errors++; $display("FAIL stall_data k=%0d got %h/%h exp 4321/fedc", k, i_out, q_out); end
      step();
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (out_vld !== (k <= 2) || out_last !== (k == 2)) begin
        errors++; $display("FAIL stall_resume k=%0d vld=%b last=%b exp %b %b", k, out_vld, out_last, k <= 2, k == 2); end
      checks++; if (i_out !== 16'sh4321 || q_out !== -16'sh0124) begin
        errors++; $display("FAIL stall_hold k=%0d got %h/%h exp 4321/fedc", k, i_out, q_out); end
      step();
    end
  endtask

  task automatic test_width();
    w_i_in = 12'sh800; w_q_in = 12'sh7FF; w_mode = 2'b00; w_in_vld = 1'b1; w_out_rdy = 1'b1;
    @(negedge clk);
    checks++; if (w_in_rdy !== 1'b1) begin errors++; $display("FAIL width_rdy got %b exp 1", w_in_rdy); end
    step();
    w_in_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (w_out_vld !== (k <= 3)) begin errors++; $display("FAIL width_vld k=%0d got %b exp %b", k, w_out_vld, k <= 3); end
      if (k <= 3) begin
        checks++; if (w_i_out !== 16'shF800 || w_q_out !== 16'sh07FF || w_out_last !== (k == 3)) begin
          errors++; $display("FAIL width_data k=%0d got %h/%h last=%b exp f800/07ff %b", k, w_i_out, w_q_out, w_out_last, k == 3); end
      end
      step();
    end
    w_out_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_in = 16'sh0BAD; q_in = 16'sh0CAB; mode = 2'b11; in_vld = 1'b1; out_rdy = 1'b1;
    step();
    in_vld = 1'b0;
    @(negedge clk);
    checks++; if (out_vld !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL rmid_copy1 vld=%b last=%b exp 1 0", out_vld, out_last); end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL rmid_rdy_in_rst got %b exp 0", in_rdy); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_vld !== 1'b0 || i_out !== 16'h0) begin errors++; $display("FAIL rmid_after vld=%b i=%h exp 0 0000", out_vld, i_out); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rmid_rdy_release got %b exp 1", in_rdy); end
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rmid_stale k=%0d got %b exp 0", k, out_vld); end
      step();
    end
  endtask

  // Model: number of copies still owed for the current estimate, plus the value they carry.
  task automatic test_random();
    int rem = 0;
    logic signed [15:0] mi = '0, mq = '0;
    logic exp_rdy;
    rst = 1'b1; in_vld = 1'b0;
    step();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst     = ($urandom_range(0, 79) == 0);
      in_vld  = 1'($urandom_range(0, 1));
      i_in    = 16'($urandom);
      q_in    = 16'($urandom);
      mode    = 2'($urandom_range(0, 3));
      out_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy = !rst && (rem == 0 || (rem == 1 && out_rdy));
      checks++; if (in_rdy !== exp_rdy) begin errors++; $display("FAIL rand_rdy cyc=%0d got %b exp %b", cyc, in_rdy, exp_rdy); end
      checks++; if (out_vld !== (rem > 0) || out_last !== (rem == 1)) begin
        errors++; $display("FAIL rand_ctl cyc=%0d vld=%b last=%b exp %b %b", cyc, out_vld, out_last, rem > 0, rem == 1); end
      checks++; if (i_out !== mi || q_out !== mq) begin
        errors++; $display("FAIL rand_data cyc=%0d got %h/%h exp %h/%h", cyc, i_out, q_out, mi, mq); end
      @(posedge clk);
      if (rst) begin
        rem = 0; mi = '0; mq = '0;
      end else begin
        if (rem > 0 && out_rdy) rem--;
        if (in_vld && exp_rdy) begin
          rem = (mode == 2'b01) ? 1 : (mode == 2'b10) ? 2 : 3;
          mi = i_in; mq = q_in;
        end
      end
      #1;
    end
    rst = 1'b0; in_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_width();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
